fetch_stage: RTL

Instruction fetch stage of the 32-bit RISC-V core. It owns the program counter, issues word requests to instruction memory, and buffers returned instructions in a 2-entry in-order queue. It presents instructions to decode, where the opcode field `instr[6:0]` drives the controller's immediate-source and main decoders. It also handles PC redirects from branch and jump resolution, including discarding stale in-flight responses.

---
 rtl/fetch_stage.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem word requests and buffers responses in a 2-entry queue.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets in a FAULT state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        misalign_fault
);

  localparam logic [1:0] DEPTH = 2'(MAX_OUTSTANDING);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_e;
`else
  typedef enum logic {ST_RUN = 1'b0} state_e;
`endif

  state_e      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [1:0]  outstanding_r, outstanding_s;
  logic [1:0]  drop_r, drop_s;
  logic [1:0]  count_r, count_s;
  logic [31:0] q_instr_r [2];
  logic [31:0] q_instr_s [2];
  logic [31:0] q_pc_r [2];
  logic [31:0] q_pc_s [2];
  logic [31:0] tag_r [2];
  logic [31:0] tag_s [2];
  logic [31:0] plus4_r;

  logic [1:0]  live_s;
  logic [2:0]  credit_s;
  logic        accept_s, rsp_s, deq_s, enq_s, flush_s;
  logic        enq_slot_s, tag_wr_idx_s;

  // Live requests are those whose responses will actually land in the queue.
  assign live_s         = outstanding_r - drop_r;
  assign credit_s       = {1'b0, count_r} + {1'b0, live_s};
  assign imem_req_valid = rst_n && (state_r == ST_RUN) && (outstanding_r < DEPTH)
                          && (credit_s < {1'b0, DEPTH});
  assign imem_addr      = pc_r;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign rsp_s          = imem_rsp_valid && (outstanding_r != 2'd0);
  assign deq_s          = instr_valid && instr_ready;
  assign enq_s          = rsp_s && (drop_r == 2'd0);
  assign enq_slot_s     = (count_r == 2'd2) || ((count_r == 2'd1) && !deq_s);
  assign tag_wr_idx_s   = (outstanding_r == 2'd1) && !rsp_s;

  assign instr_valid    = (count_r != 2'd0);
  assign instr          = q_instr_r[0];
  assign instr_pc       = q_pc_r[0];
  assign instr_pc_plus4 = plus4_r;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign_fault = (state_r == ST_FAULT);
`else
  assign misalign_fault = 1'b0;
`endif

  // Next-state: request/response accounting, queue, tag FIFO, redirect and fault handling.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    outstanding_s = outstanding_r;
    drop_s        = drop_r;
    count_s       = count_r;
    q_instr_s     = q_instr_r;
    q_pc_s        = q_pc_r;
    tag_s         = tag_r;
    flush_s       = 1'b0;

    case ({accept_s, rsp_s})
      2'b10:   outstanding_s = outstanding_r + 2'd1;
      2'b01:   outstanding_s = outstanding_r - 2'd1;
      default: outstanding_s = outstanding_r;
    endcase

    if (rsp_s && (drop_r != 2'd0)) begin
      drop_s = drop_r - 2'd1;
    end else begin
      drop_s = drop_r;
    end

    // Tag FIFO tracks every outstanding request, dropped or not, oldest at slot 0.
    if (rsp_s) begin
      tag_s[0] = tag_r[1];
    end else begin
      tag_s[0] = tag_r[0];
    end
    if (accept_s) begin
      if (tag_wr_idx_s) begin
        tag_s[1] = pc_r;
      end else begin
        tag_s[0] = pc_r;
      end
    end else begin
      tag_s[1] = tag_s[1];
    end

    if (deq_s) begin
      q_instr_s[0] = q_instr_r[1];
      q_pc_s[0]    = q_pc_r[1];
    end else begin
      q_instr_s[0] = q_instr_r[0];
      q_pc_s[0]    = q_pc_r[0];
    end
    if (enq_s) begin
      if (enq_slot_s) begin
        q_instr_s[1] = imem_rsp_data;
        q_pc_s[1]    = tag_r[0];
      end else begin
        q_instr_s[0] = imem_rsp_data;
        q_pc_s[0]    = tag_r[0];
      end
    end else begin
      q_instr_s[1] = q_instr_s[1];
    end

    case ({enq_s, deq_s})
      2'b10:   count_s = count_r + 2'd1;
      2'b01:   count_s = count_r - 2'd1;
      default: count_s = count_r;
    endcase

    case (state_r)
      ST_RUN: begin
        if (redirect_valid) begin
          flush_s = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (redirect_pc[1:0] != 2'b00) begin
            state_s = ST_FAULT;
          end else begin
            state_s = ST_RUN;
          end
`else
          state_s = ST_RUN;
`endif
        end else begin
          state_s = ST_RUN;
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: begin
        flush_s = 1'b1;
        if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_FAULT;
        end
      end
`endif
      default: begin
        state_s = ST_RUN;
      end
    endcase

    // Everything still in flight after this cycle's accounting belongs to the old stream.
    if (flush_s) begin
      count_s = 2'd0;
      drop_s  = outstanding_s;
    end else begin
      count_s = count_s;
    end

    if (redirect_valid) begin
      pc_s = redirect_pc & 32'hFFFF_FFFC;
    end else if (accept_s) begin
      pc_s = pc_r + 32'd4;
    end else begin
      pc_s = pc_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      outstanding_r <= 2'd0;
      drop_r        <= 2'd0;
      count_r       <= 2'd0;
      q_instr_r[0]  <= 32'd0;
      q_instr_r[1]  <= 32'd0;
      q_pc_r[0]     <= 32'd0;
      q_pc_r[1]     <= 32'd0;
      tag_r[0]      <= 32'd0;
      tag_r[1]      <= 32'd0;
      plus4_r       <= 32'd4;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      outstanding_r <= outstanding_s;
      drop_r        <= drop_s;
      count_r       <= count_s;
      q_instr_r     <= q_instr_s;
      q_pc_r        <= q_pc_s;
      tag_r         <= tag_s;
      plus4_r       <= q_pc_s[0] + 32'd4;
    end
  end

endmodule
